// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (cpu port) and the loader DMA (dma port). Each accepted access is
// registered, drives the memory for exactly one cycle, then completes with a
// one-cycle done pulse. Optional feature macro: DMEM_ARB_BOUNDS_EN turns
// out-of-range addresses into error completions instead of wrapping them.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic              mem_readEn,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
  logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;
  logic              dmaWins;
  logic              inBounds;
  logic              accessActive;

`ifdef DMEM_ARB_BOUNDS_EN
  assign inBounds    = (addr_q < ADDR_W'(MEM_DEPTH));
  assign mem_address = addr_q;
  assign cpu_err     = cpu_done & ~inBounds;
  assign dma_err     = dma_done & ~inBounds;
`else
  logic unusedAddrBits;
  assign inBounds       = 1'b1;
  assign mem_address    = {{(ADDR_W-IDX_W){1'b0}}, addr_q[IDX_W-1:0]};
  assign unusedAddrBits = ^addr_q[ADDR_W-1:IDX_W];
  assign cpu_err        = 1'b0;
  assign dma_err        = 1'b0;
`endif

  // Pick the winner: a lone requester always wins; a tie goes to cpu unless
  // dma has lost MAX_WAIT times in a row, or alternates in round-robin mode.
  always_comb begin
    dmaWins = dma_req;
    if (cpu_req && dma_req) begin
      if (CPU_PRIORITY != 0) begin
        dmaWins = (waitCnt_q >= CNT_W'(MAX_WAIT));
      end else begin
        dmaWins = rrPtr_q;
      end
    end
  end

  // Sequence IDLE/RESP -> ACCESS -> RESP, latching the winner's request at
  // arbitration and capturing read data at the end of the access cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rrPtr_d    = rrPtr_q;
    waitCnt_d  = waitCnt_q;
    cpuRdata_d = cpuRdata_q;
    dmaRdata_d = dmaRdata_q;
    case (state_q)
      ACCESS: begin
        state_d = RESP;
        if (!inBounds) begin
          if (owner_q) dmaRdata_d = '0;
          else         cpuRdata_d = '0;
        end else if (!we_q) begin
          if (owner_q) dmaRdata_d = mem_ReadData;
          else         cpuRdata_d = mem_ReadData;
        end
      end
      default: begin
        if (cpu_req || dma_req) begin
          state_d = ACCESS;
          owner_d = dmaWins;
          we_d    = dmaWins ? dma_we    : cpu_we;
          addr_d  = dmaWins ? dma_addr  : cpu_addr;
          wdata_d = dmaWins ? dma_wdata : cpu_wdata;
          rrPtr_d = ~dmaWins;
          if (dmaWins) begin
            waitCnt_d = '0;
          end else if (dma_req && (waitCnt_q != CNT_W'(MAX_WAIT))) begin
            waitCnt_d = waitCnt_q + 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset drops any in-flight access and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rrPtr_q    <= 1'b0;
      waitCnt_q  <= '0;
      cpuRdata_q <= '0;
      dmaRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rrPtr_q    <= rrPtr_d;
      waitCnt_q  <= waitCnt_d;
      cpuRdata_q <= cpuRdata_d;
      dmaRdata_q <= dmaRdata_d;
    end
  end

  assign accessActive  = (state_q == ACCESS);
  assign cpu_gnt       = accessActive & ~owner_q;
  assign dma_gnt       = accessActive & owner_q;
  assign cpu_done      = (state_q == RESP) & ~owner_q;
  assign dma_done      = (state_q == RESP) & owner_q;
  assign cpu_rdata     = cpuRdata_q;
  assign dma_rdata     = dmaRdata_q;
  assign mem_writeEn   = accessActive & we_q & inBounds;
  assign mem_readEn    = accessActive & ~we_q & inBounds;
  assign mem_WriteData = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a priority-mode instance backed by a
// 1024-word memory model, plus a round-robin instance for the tie pattern.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        memInit;
  logic        cpuReq, cpuWe, dmaReq, dmaWe;
  logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata;
  logic        cpuGnt, cpuDone, cpuErr, dmaGnt, dmaDone, dmaErr;
  logic [31:0] cpuRdata, dmaRdata;
  logic        memReadEn, memWriteEn;
  logic [31:0] memAddress, memWriteData, memReadData;
  logic [31:0] memArray [0:1023];

  logic        rrCpuReq, rrDmaReq;
  logic        rrCpuGnt, rrCpuDone, rrCpuErr, rrDmaGnt, rrDmaDone, rrDmaErr;
  logic [31:0] rrCpuRdata, rrDmaRdata;
  logic        rrReadEn, rrWriteEn;
  logic [31:0] rrAddress, rrWriteData;
  logic [31:0] rrReadData;

  int total = 0;
  int bad   = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024),
                 .CPU_PRIORITY(1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(cpuGnt), .cpu_done(cpuDone), .cpu_rdata(cpuRdata), .cpu_err(cpuErr),
    .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_gnt(dmaGnt), .dma_done(dmaDone), .dma_rdata(dmaRdata), .dma_err(dmaErr),
    .mem_readEn(memReadEn), .mem_writeEn(memWriteEn), .mem_address(memAddress),
    .mem_WriteData(memWriteData), .mem_ReadData(memReadData)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024),
                 .CPU_PRIORITY(0), .MAX_WAIT(4)) dutRr (
    .clk(clk), .rst(rst),
    .cpu_req(rrCpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(rrCpuGnt), .cpu_done(rrCpuDone), .cpu_rdata(rrCpuRdata), .cpu_err(rrCpuErr),
    .dma_req(rrDmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_gnt(rrDmaGnt), .dma_done(rrDmaDone), .dma_rdata(rrDmaRdata), .dma_err(rrDmaErr),
    .mem_readEn(rrReadEn), .mem_writeEn(rrWriteEn), .mem_address(rrAddress),
    .mem_WriteData(rrWriteData), .mem_ReadData(rrReadData)
  );

  assign rrReadData  = 32'h0;
  assign memReadData = memArray[memAddress[9:0]];

  // Memory model: preloaded while memInit is high, writes land on negedge.
  always @(negedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 1024; i++) memArray[i] <= 32'h0;
      memArray[0] <= 32'h0BAD_F00D;
      memArray[3] <= 32'hA5A5_A5A5;
    end else if (memWriteEn) begin
      memArray[memAddress[9:0]] <= memWriteData;
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isDma, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (isDma) begin
      dmaReq = req; dmaWe = we; dmaAddr = addr; dmaWdata = wdata;
    end else begin
      cpuReq = req; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] flags();
    return {24'h0, cpuGnt, cpuDone, cpuErr, dmaGnt, dmaDone, dmaErr, memReadEn, memWriteEn};
  endfunction

  initial begin
    rst = 1'b0; memInit = 1'b1;
    rrCpuReq = 1'b0; rrDmaReq = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    checkOutput("resetFlags", flags(), 32'h0);
    checkOutput("resetCpuRdata", cpuRdata, 32'h0);
    checkOutput("resetMemAddr", memAddress, 32'h0);
    rst = 1'b1; memInit = 1'b0;
    tick();

    $display("[TB] cpu write addr 5");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    tick();
    checkOutput("wrAccessFlags", flags(), 32'h81);
    checkOutput("wrAddr", memAddress, 32'd5);
    checkOutput("wrData", memWriteData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd99, 32'h0);
    #1;
    checkOutput("wrAddrLatched", memAddress, 32'd5);
    checkOutput("wrDataLatched", memWriteData, 32'hDEAD_BEEF);
    tick();
    checkOutput("wrRespFlags", flags(), 32'h40);
    checkOutput("wrMemContents", memArray[5], 32'hDEAD_BEEF);
    checkOutput("wrRdataUnchanged", cpuRdata, 32'h0);
    tick();
    checkOutput("wrIdleFlags", flags(), 32'h0);

    $display("[TB] cpu read addr 5");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
    tick();
    checkOutput("rdAccessFlags", flags(), 32'h82);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rdRespFlags", flags(), 32'h40);
    checkOutput("rdData", cpuRdata, 32'hDEAD_BEEF);
    tick();

    $display("[TB] dma read addr 3 then cpu traffic");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd3, 32'h0);
    tick();
    checkOutput("dmaRdAccessFlags", flags(), 32'h12);
    checkOutput("dmaRdAddr", memAddress, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd10, 32'h1111_2222);
    tick();
    checkOutput("dmaRdRespFlags", flags(), 32'h08);
    checkOutput("dmaRdData", dmaRdata, 32'hA5A5_A5A5);
    checkOutput("dmaRdCpuIsolated", cpuRdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("isoCpuWrFlags", flags(), 32'h81);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd10, 32'h0);
    tick();
    checkOutput("isoCpuWrDone", flags(), 32'h40);
    tick();
    checkOutput("isoCpuRdFlags", flags(), 32'h82);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("isoCpuRdData", cpuRdata, 32'h1111_2222);
    checkOutput("isoDmaRdataHeld", dmaRdata, 32'hA5A5_A5A5);
    tick();

    $display("[TB] cpu read addr 1024");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0);
    tick();
`ifdef DMEM_ARB_BOUNDS_EN
    checkOutput("oobAccessFlags", flags(), 32'h80);
`else
    checkOutput("oobAccessFlags", flags(), 32'h82);
    checkOutput("oobWrapAddr", memAddress, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`ifdef DMEM_ARB_BOUNDS_EN
    checkOutput("oobRespFlags", flags(), 32'h60);
    checkOutput("oobRdata", cpuRdata, 32'h0);
`else
    checkOutput("oobRespFlags", flags(), 32'h40);
    checkOutput("oobRdata", cpuRdata, 32'h0BAD_F00D);
`endif
    tick();

    $display("[TB] starvation guard, both requests held");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd2, 32'h0);
    for (int g = 0; g < 10; g++) begin
      logic expDma;
      expDma = ((g % 5) == 4);
      tick();
      checkOutput($sformatf("starveGnt%0d", g), {30'h0, cpuGnt, dmaGnt}, {30'h0, ~expDma, expDma});
      tick();
      checkOutput($sformatf("starveDone%0d", g), {30'h0, cpuDone, dmaDone}, {30'h0, ~expDma, expDma});
      if (g == 9) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    tick();
    checkOutput("starveIdle", flags(), 32'h0);

    $display("[TB] round-robin tie");
    rrCpuReq = 1'b1; rrDmaReq = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      logic expCpu, expDma;
      expCpu = (c == 1) || (c == 5);
      expDma = (c == 3) || (c == 7);
      tick();
      checkOutput($sformatf("rrGnt%0d", c), {30'h0, rrCpuGnt, rrDmaGnt}, {30'h0, expCpu, expDma});
    end
    checkOutput("rrLastDone", {31'h0, rrDmaDone}, 32'h1);
    rrCpuReq = 1'b0; rrDmaReq = 1'b0;
    tick();

    $display("[TB] reset during dma write access");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd7, 32'h0000_1234);
    tick();
    checkOutput("rstAccessFlags", flags(), 32'h11);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstWriteEnDrop", flags(), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rstNoPartialWrite", memArray[7], 32'h0);
    tick();
    tick();
    rst = 1'b1;
    checkOutput("rstReleaseFlags", flags(), 32'h0);
    checkOutput("rstDmaRdata", dmaRdata, 32'h0);
    checkOutput("rstCpuRdata", cpuRdata, 32'h0);
    tick();
    checkOutput("rstNoDmaDone", flags(), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
    tick();
    checkOutput("postRstGnt", flags(), 32'h82);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("postRstRdata", cpuRdata, 32'hDEAD_BEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
